// File: rtl/cla_addsub_pipe.sv
// Pipelined two's-complement adder/subtractor: one GROUP_W-bit carry-lookahead
// slice per stage, inter-group carry registered, global-advance handshake.
module cla_addsub_pipe #(
   parameter int WIDTH   = 16,
   parameter int GROUP_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_sub,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             out_borrow,
   output logic             out_ovf,
   output logic             out_zero
);

   localparam int NSTG = WIDTH / GROUP_W;

   // Carry k is a two-level sum of products over p/g and cin, not a ripple chain.
   function automatic logic [GROUP_W:0] lookahead(input logic [GROUP_W-1:0] p,
                                                  input logic [GROUP_W-1:0] g,
                                                  input logic cin);
      logic [GROUP_W:0] c;
      logic             term;
      c    = '0;
      c[0] = cin;
      for (int k = 1; k <= GROUP_W; k++) begin
         term = cin;
         for (int j = 0; j < k; j++) term = term & p[j];
         c[k] = term;
         for (int j = 0; j < k; j++) begin
            term = g[j];
            for (int m = j + 1; m < k; m++) term = term & p[m];
            c[k] = c[k] | term;
         end
      end
      return c;
   endfunction

   logic [WIDTH-1:0] sum_p [NSTG];
   logic [WIDTH-1:0] a_p   [NSTG];
   logic [WIDTH-1:0] bx_p  [NSTG];
   logic [NSTG-1:0]  carry_p;
   logic [NSTG-1:0]  sub_p;
   logic [NSTG-1:0]  vld_p;
   logic             ovf_p;
   logic             zero_p;

   logic [WIDTH-1:0] src_sum [NSTG];
   logic [WIDTH-1:0] src_a   [NSTG];
   logic [WIDTH-1:0] src_bx  [NSTG];
   logic [WIDTH-1:0] nxt_sum [NSTG];
   logic [NSTG-1:0]  src_c;
   logic [NSTG-1:0]  src_sub;
   logic [NSTG-1:0]  src_vld;
   logic [NSTG-1:0]  nxt_c;
   logic [GROUP_W-1:0] grp_p;
   logic [GROUP_W-1:0] grp_g;
   logic [GROUP_W:0]   grp_c;
   logic             msb_cin;
   logic             adv;

   assign adv      = ~out_valid | out_ready;
   assign in_ready = adv;

   always_comb begin
      src_a[0]   = in_a;
      src_bx[0]  = in_b ^ {WIDTH{in_sub}};
      src_sum[0] = '0;
      src_c[0]   = in_sub;
      src_sub[0] = in_sub;
      src_vld[0] = in_valid & adv;
      for (int s = 1; s < NSTG; s++) begin
         src_a[s]   = a_p[s-1];
         src_bx[s]  = bx_p[s-1];
         src_sum[s] = sum_p[s-1];
         src_c[s]   = carry_p[s-1];
         src_sub[s] = sub_p[s-1];
         src_vld[s] = vld_p[s-1];
      end
      grp_p   = '0;
      grp_g   = '0;
      grp_c   = '0;
      msb_cin = 1'b0;
      for (int s = 0; s < NSTG; s++) begin
         grp_p      = src_a[s][s*GROUP_W +: GROUP_W] ^ src_bx[s][s*GROUP_W +: GROUP_W];
         grp_g      = src_a[s][s*GROUP_W +: GROUP_W] & src_bx[s][s*GROUP_W +: GROUP_W];
         grp_c      = lookahead(grp_p, grp_g, src_c[s]);
         nxt_sum[s] = src_sum[s];
         nxt_sum[s][s*GROUP_W +: GROUP_W] = grp_p ^ grp_c[GROUP_W-1:0];
         nxt_c[s]   = grp_c[GROUP_W];
         if (s == NSTG - 1) msb_cin = grp_c[GROUP_W-1];
      end
   end

   // ---- stage registers: control (valid) ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   vld_p <= '0;
      else if (adv) vld_p <= src_vld;
   end

   // ---- stage registers: datapath, last stage also holds the flags ----
   always_ff @(posedge clk) begin
      if (adv) begin
         for (int s = 0; s < NSTG; s++) begin
            sum_p[s]   <= nxt_sum[s];
            a_p[s]     <= src_a[s];
            bx_p[s]    <= src_bx[s];
            carry_p[s] <= nxt_c[s];
            sub_p[s]   <= src_sub[s];
         end
         ovf_p  <= msb_cin ^ nxt_c[NSTG-1];
         zero_p <= ~|nxt_sum[NSTG-1];
      end
   end

   // Outputs read zero whenever no result is presented (including under reset).
   assign out_valid  = vld_p[NSTG-1];
   assign out_sum    = out_valid ? sum_p[NSTG-1] : '0;
   assign out_cout   = out_valid & carry_p[NSTG-1];
   assign out_borrow = out_valid & sub_p[NSTG-1] & ~carry_p[NSTG-1];
   assign out_ovf    = out_valid & ovf_p;
   assign out_zero   = out_valid & zero_p;

endmodule

// File: tb/tb_cla_addsub_pipe.sv
// Scoreboarded bench for cla_addsub_pipe: directed vector table, latency,
// random full-rate and backpressure streams, full-pipe and mid-stream reset.
module tb_cla_addsub_pipe;

   logic        clk = 1'b0;
   logic        rst_n, in_valid, in_ready, in_sub, out_valid, out_ready;
   logic        out_cout, out_borrow, out_ovf, out_zero;
   logic [15:0] in_a, in_b, out_sum;

   always #5 clk = ~clk;

   cla_addsub_pipe #(.WIDTH(16), .GROUP_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_sub(in_sub), .in_a(in_a), .in_b(in_b), .out_valid(out_valid),
      .out_ready(out_ready), .out_sum(out_sum), .out_cout(out_cout),
      .out_borrow(out_borrow), .out_ovf(out_ovf), .out_zero(out_zero)
   );

   typedef struct packed {
      logic [15:0] sum;
      logic        cout;
      logic        borrow;
      logic        ovf;
      logic        zero;
   } exp_t;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        sub;
      exp_t        e;
   } vec_t;

   exp_t q[$];
   int   checks = 0, errors = 0;
   int   acc_cnt = 0, out_cnt = 0;
   logic stalled_prev = 1'b0;
   exp_t held;

   function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic s);
      exp_t        r;
      logic [15:0] bb;
      logic [16:0] full;
      bb       = s ? ~b : b;
      full     = {1'b0, a} + {1'b0, bb} + {16'd0, s};
      r.sum    = full[15:0];
      r.cout   = full[16];
      r.borrow = s & ~full[16];
      r.ovf    = (a[15] == bb[15]) && (full[15] != a[15]);
      r.zero   = (full[15:0] == 16'd0);
      return r;
   endfunction

   function automatic vec_t mk(input logic [15:0] a, input logic [15:0] b, input logic s,
                               input logic [15:0] sum, input logic c, input logic bw,
                               input logic o, input logic z);
      vec_t v;
      v.a = a; v.b = b; v.sub = s;
      v.e.sum = sum; v.e.cout = c; v.e.borrow = bw; v.e.ovf = o; v.e.zero = z;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One clock cycle: drive at the falling edge, sample 1 ns later, score transfers.
   task automatic cycle(input logic v, input logic [15:0] a, input logic [15:0] b,
                        input logic s, input exp_t e, input logic rdy);
      exp_t got, want;
      @(negedge clk);
      in_valid = v; in_a = a; in_b = b; in_sub = s; out_ready = rdy;
      #1;
      got = {out_sum, out_cout, out_borrow, out_ovf, out_zero};
      if (stalled_prev) check("stall_hold", 32'(got), 32'(held));
      if (out_valid && !out_ready) check("stall_in_ready", 32'(in_ready), 32'd0);
      stalled_prev = out_valid & ~out_ready;
      held = got;
      if (in_valid && in_ready) begin
         q.push_back(e);
         acc_cnt++;
      end
      if (out_valid && out_ready) begin
         out_cnt++;
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL spurious_output: got %0h with empty scoreboard", got);
         end else begin
            want = q.pop_front();
            if (got !== want) begin
               errors++;
               $display("FAIL result: got %0h expected %0h", got, want);
            end
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 16'd0, 16'd0, 1'b0, '0, 1'b1);
   endtask

   task automatic latency_seq(input logic [15:0] a, input logic [15:0] b, input logic s,
                              input exp_t e);
      int n;
      cycle(1'b1, a, b, s, e, 1'b1);
      n = 0;
      do begin
         cycle(1'b0, 16'd0, 16'd0, 1'b0, '0, 1'b1);
         n++;
      end while (!out_valid && n < 20);
      check("latency", 32'(n), 32'd4);
   endtask

   vec_t        tbl[12];
   logic [15:0] ra, rb;
   logic        rs, rv, rr;

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; out_ready = 1'b0;
      #3;
      check("reset_out_valid", 32'(out_valid), 32'd0);
      check("reset_outputs", 32'({out_sum, out_cout, out_borrow, out_ovf, out_zero}), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("in_ready_after_reset", 32'(in_ready), 32'd1);

      tbl[0]  = mk(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1, 0, 0, 1);
      tbl[1]  = mk(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 0, 0, 1, 0);
      tbl[2]  = mk(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1, 0, 1, 0);
      tbl[3]  = mk(16'h0003, 16'h0005, 1'b1, 16'hFFFE, 0, 1, 0, 0);
      tbl[4]  = mk(16'h1234, 16'h1234, 1'b1, 16'h0000, 1, 0, 0, 1);
      tbl[5]  = mk(16'h0FFF, 16'h0001, 1'b0, 16'h1000, 0, 0, 0, 0);
      tbl[6]  = mk(16'h0000, 16'h0000, 1'b1, 16'h0000, 1, 0, 0, 1);
      tbl[7]  = mk(16'h8000, 16'h8000, 1'b0, 16'h0000, 1, 0, 1, 1);
      tbl[8]  = mk(16'h00F0, 16'h0F10, 1'b0, 16'h1000, 0, 0, 0, 0);
      tbl[9]  = mk(16'h5555, 16'hAAAA, 1'b0, 16'hFFFF, 0, 0, 0, 0);
      tbl[10] = mk(16'h0001, 16'hFFFF, 1'b1, 16'h0002, 0, 1, 0, 0);
      tbl[11] = mk(16'h8000, 16'h7FFF, 1'b1, 16'h0001, 1, 0, 1, 0);

      latency_seq(tbl[0].a, tbl[0].b, tbl[0].sub, tbl[0].e);

      for (int i = 0; i < 12; i++) cycle(1'b1, tbl[i].a, tbl[i].b, tbl[i].sub, tbl[i].e, 1'b1);
      idle(8);
      check("table_drain", 32'(q.size()), 32'd0);

      // Back-to-back random stream at full rate.
      out_cnt = 0;
      for (int i = 0; i < 1000; i++) begin
         ra = 16'($urandom); rb = 16'($urandom); rs = 1'($urandom_range(0, 1));
         cycle(1'b1, ra, rb, rs, model(ra, rb, rs), 1'b1);
      end
      check("full_rate_outputs", 32'(out_cnt), 32'd996);
      idle(8);
      check("stream_count", 32'(out_cnt), 32'd1000);

      // Random valid and backpressure.
      for (int i = 0; i < 400; i++) begin
         ra = 16'($urandom); rb = 16'($urandom); rs = 1'($urandom_range(0, 1));
         rv = 1'($urandom_range(0, 1)); rr = 1'($urandom_range(0, 1));
         cycle(rv, ra, rb, rs, model(ra, rb, rs), rr);
      end
      idle(10);
      check("backpressure_drain", 32'(q.size()), 32'd0);

      // Downstream held off: exactly four operands fit.
      acc_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         ra = 16'($urandom); rb = 16'($urandom); rs = 1'($urandom_range(0, 1));
         cycle(1'b1, ra, rb, rs, model(ra, rb, rs), 1'b0);
      end
      check("full_accept", 32'(acc_cnt), 32'd4);
      idle(10);
      check("full_drain", 32'(q.size()), 32'd0);

      // Reset with three items in flight, the oldest being presented.
      for (int i = 0; i < 3; i++) begin
         ra = 16'($urandom); rb = 16'($urandom);
         cycle(1'b1, ra, rb, 1'b0, model(ra, rb, 1'b0), 1'b1);
      end
      cycle(1'b0, 16'd0, 16'd0, 1'b0, '0, 1'b0);
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b0;
      #1;
      check("pre_reset_valid", 32'(out_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      check("mid_reset_valid", 32'(out_valid), 32'd0);
      check("mid_reset_sum", 32'(out_sum), 32'd0);
      q.delete();
      stalled_prev = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         cycle(1'b0, 16'd0, 16'd0, 1'b0, '0, 1'b1);
         check("post_reset_idle", 32'(out_valid), 32'd0);
      end
      latency_seq(16'h0FFF, 16'h0001, 1'b0, model(16'h0FFF, 16'h0001, 1'b0));
      latency_seq(16'h0003, 16'h0005, 1'b1, model(16'h0003, 16'h0005, 1'b1));
      idle(4);
      check("final_drain", 32'(q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
